// File: rtl/sfu_commit_arbiter.sv
// sfu_commit_arbiter: merges SFU PE commit responses into one commit stream
// for the gather stage. Round-robin grant, optional sop..eop packet lock,
// registered output with a one-entry skid so the stage runs 1 beat/cycle.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_sop/in_eop/in_data/in_ready
//                        per-PE beat stream; lane i at in_data[i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_sop/out_eop/out_data/out_src/out_ready
//                        merged beat stream, out_src = originating PE
//   perf_stall_cycles, perf_lock_block_cycles
//                        64-bit saturating counters, only with SFU_COMMIT_PERF_EN
//
// Build option: define SFU_COMMIT_PERF_EN to add the perf counters.

module sfu_commit_arbiter #(
  parameter int NUM_INPUTS   = 5,
  parameter int DATA_WIDTH   = 128,
  parameter int LOCK_PACKETS = 1,
  localparam int SW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_sop,
  input  logic [NUM_INPUTS-1:0]            in_eop,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic [SW-1:0]                    out_src,
  input  logic                             out_ready
`ifdef SFU_COMMIT_PERF_EN
  ,
  output logic [63:0]                      perf_stall_cycles,
  output logic [63:0]                      perf_lock_block_cycles
`endif
);

  localparam bit LOCK_EN = (LOCK_PACKETS != 0);

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_t;

  typedef logic [SW+1:0] wide_t;

  lock_state_t state;

  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] lock_src;
  logic [SW-1:0] grant_idx;
  logic          grant_ok;

  logic [DATA_WIDTH-1:0] lane [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_sop;
  logic                  sel_eop;

  logic                  can_accept;
  logic                  accept;
  logic                  drain;

  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_sop;
  logic                  skid_eop;
  logic [SW-1:0]         skid_src;

  // (base + off) mod NUM_INPUTS; off < NUM_INPUTS so one subtract suffices.
  function automatic logic [SW-1:0] wrap_add(
    input logic [SW-1:0] base,
    input int            off
  );
    wide_t s;
    s = wide_t'(base) + wide_t'(off);
    if (s >= wide_t'(NUM_INPUTS))
      s = s - wide_t'(NUM_INPUTS);
    return s[SW-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++)
      lane[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan downward so the smallest offset from rr_ptr wins.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    if (state == LOCKED) begin
      grant_ok  = in_valid[lock_src];
      grant_idx = lock_src;
    end else begin
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        if (in_valid[wrap_add(rr_ptr, k)]) begin
          grant_ok  = 1'b1;
          grant_idx = wrap_add(rr_ptr, k);
        end
      end
    end
  end

  assign sel_data   = lane[grant_idx];
  assign sel_sop    = in_sop[grant_idx];
  assign sel_eop    = in_eop[grant_idx];

  assign can_accept = !skid_valid;
  assign accept     = grant_ok && can_accept && !reset;
  assign drain      = out_valid && out_ready;

  always_comb begin
    in_ready = '0;
    if (accept)
      in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      lock_src   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_src    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_sop   <= 1'b0;
      skid_eop   <= 1'b0;
      skid_src   <= '0;
    end else begin
      // rr_ptr only moves past a source once its packet is complete.
      if (accept) begin
        if (state == IDLE) begin
          if (LOCK_EN && sel_sop && !sel_eop) begin
            state    <= LOCKED;
            lock_src <= grant_idx;
          end else begin
            rr_ptr <= wrap_add(grant_idx, 1);
          end
        end else if (sel_eop) begin
          state  <= IDLE;
          rr_ptr <= wrap_add(grant_idx, 1);
        end
      end

      if (skid_valid) begin
        if (drain) begin
          out_valid  <= 1'b1;
          out_data   <= skid_data;
          out_sop    <= skid_sop;
          out_eop    <= skid_eop;
          out_src    <= skid_src;
          skid_valid <= 1'b0;
        end
      end else if (!out_valid || out_ready) begin
        out_valid <= accept;
        if (accept) begin
          out_data <= sel_data;
          out_sop  <= sel_sop;
          out_eop  <= sel_eop;
          out_src  <= grant_idx;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= sel_data;
        skid_sop   <= sel_sop;
        skid_eop   <= sel_eop;
        skid_src   <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept && state == LOCKED)
      assert (!sel_sop)
      else $error("sfu_commit_arbiter: sop on src %0d before eop", lock_src);
  end

`ifdef SFU_COMMIT_PERF_EN
  logic [NUM_INPUTS-1:0] others;

  always_comb begin
    others           = in_valid;
    others[lock_src] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles      <= '0;
      perf_lock_block_cycles <= '0;
    end else begin
      if (out_valid && !out_ready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 64'd1;
      if (state == LOCKED && |others && perf_lock_block_cycles != '1)
        perf_lock_block_cycles <= perf_lock_block_cycles + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sfu_commit_arbiter.sv
// tb_sfu_commit_arbiter: directed bench for sfu_commit_arbiter
// (NUM_INPUTS=5, DATA_WIDTH=128, LOCK_PACKETS=1).

module tb_sfu_commit_arbiter;

  localparam int N  = 5;
  localparam int DW = 128;

  logic            clk;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_sop;
  logic [N-1:0]    in_eop;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_sop;
  logic            out_eop;
  logic [2:0]      out_src;
  logic            out_ready;
`ifdef SFU_COMMIT_PERF_EN
  logic [63:0]     perf_stall_cycles;
  logic [63:0]     perf_lock_block_cycles;
`endif

  int vectors;
  int miscompares;

  sfu_commit_arbiter #(
    .NUM_INPUTS  (N),
    .DATA_WIDTH  (DW),
    .LOCK_PACKETS(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sop   (in_sop),
    .in_eop   (in_eop),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_src  (out_src),
    .out_ready(out_ready)
`ifdef SFU_COMMIT_PERF_EN
    ,
    .perf_stall_cycles     (perf_stall_cycles),
    .perf_lock_block_cycles(perf_lock_block_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic v, input logic s,
                     input logic e, input logic [127:0] d);
    in_valid[i]          = v;
    in_sop[i]            = s;
    in_eop[i]            = e;
    in_data[i*DW +: DW]  = d;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [2:0] src, input logic [127:0] d);
    chk({tag, ".valid"}, out_valid, v);
    chk({tag, ".src"}, out_src, src);
    chk({tag, ".data"}, out_data, d);
  endtask

  int exp_src [6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_valid    = '0;
    in_data     = '0;
    in_sop      = '0;
    in_eop      = '0;
    out_ready   = 1'b0;
    exp_src     = '{0, 1, 3, 0, 1, 3};

    // reset: in_ready stays low even with a requester
    put(0, 1'b1, 1'b1, 1'b1, 128'h11);
    settle();
    chk("rst.in_ready", in_ready, 5'b00000);
    tick();
    tick();
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.out_sop", out_sop, 1'b0);
    chk("rst.out_eop", out_eop, 1'b0);
    chk("rst.out_src", out_src, 3'd0);
    chk("rst.out_data", out_data, 128'h0);
    reset    = 1'b0;
    in_valid = '0;

    // single beat from input 2
    out_ready = 1'b1;
    put(2, 1'b1, 1'b1, 1'b1, 128'hA5);
    settle();
    chk("single.in_ready", in_ready, 5'b00100);
    tick();
    chk_out("single", 1'b1, 3'd2, 128'hA5);
    chk("single.sop", out_sop, 1'b1);
    chk("single.eop", out_eop, 1'b1);
    in_valid = '0;
    tick();
    chk("single.drained", out_valid, 1'b0);

    // rr_ptr is now 3: inputs 0 and 3 pending -> 3 first
    put(0, 1'b1, 1'b1, 1'b1, 128'h100);
    put(3, 1'b1, 1'b1, 1'b1, 128'h103);
    settle();
    chk("rr3.in_ready", in_ready, 5'b01000);
    tick();
    chk_out("rr3", 1'b1, 3'd3, 128'h103);
    // rr_ptr 4: inputs 0 and 4 pending -> 4 first
    in_valid[3] = 1'b0;
    put(4, 1'b1, 1'b1, 1'b1, 128'h104);
    settle();
    chk("rr4.in_ready", in_ready, 5'b10000);
    tick();
    chk_out("rr4", 1'b1, 3'd4, 128'h104);

    // round robin over 0,1,3 starting at rr_ptr 0
    in_valid = '0;
    put(0, 1'b1, 1'b1, 1'b1, 128'h100);
    put(1, 1'b1, 1'b1, 1'b1, 128'h101);
    put(3, 1'b1, 1'b1, 1'b1, 128'h103);
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("rr.in_ready", in_ready, 5'(1 << exp_src[k]));
      tick();
      chk_out("rr", 1'b1, 3'(exp_src[k]), 128'h100 + 128'(exp_src[k]));
    end

    // rr_ptr 4 -> input 0 alone brings rr_ptr to 1
    in_valid = '0;
    put(0, 1'b1, 1'b1, 1'b1, 128'h200);
    settle();
    chk("pre_lock.in_ready", in_ready, 5'b00001);
    tick();
    chk_out("pre_lock", 1'b1, 3'd0, 128'h200);

    // 3-beat packet on input 1 while input 0 waits
    put(1, 1'b1, 1'b1, 1'b0, 128'h301);
    settle();
    chk("lock0.in_ready", in_ready, 5'b00010);
    tick();
    chk_out("lock0", 1'b1, 3'd1, 128'h301);
    chk("lock0.sop", out_sop, 1'b1);
    chk("lock0.eop", out_eop, 1'b0);
    in_valid[1] = 1'b0;
    settle();
    chk("lock_gap.in_ready", in_ready, 5'b00000);
    tick();
    chk("lock_gap.out_valid", out_valid, 1'b0);
    put(1, 1'b1, 1'b0, 1'b0, 128'h302);
    settle();
    chk("lock1.in_ready", in_ready, 5'b00010);
    tick();
    chk_out("lock1", 1'b1, 3'd1, 128'h302);
    put(1, 1'b1, 1'b0, 1'b1, 128'h303);
    settle();
    chk("lock2.in_ready", in_ready, 5'b00010);
    tick();
    chk_out("lock2", 1'b1, 3'd1, 128'h303);
    chk("lock2.eop", out_eop, 1'b1);
    in_valid[1] = 1'b0;
    settle();
    chk("unlock.in_ready", in_ready, 5'b00001);
    tick();
    chk_out("unlock", 1'b1, 3'd0, 128'h200);
    in_valid = '0;
    tick();
    chk("unlock.drained", out_valid, 1'b0);

    // backpressure on an input-4 stream
    out_ready = 1'b0;
    put(4, 1'b1, 1'b1, 1'b1, 128'h400);
    settle();
    chk("bp0.in_ready", in_ready, 5'b10000);
    tick();
    chk_out("bp0", 1'b1, 3'd4, 128'h400);
    put(4, 1'b1, 1'b1, 1'b1, 128'h401);
    settle();
    chk("bp1.in_ready", in_ready, 5'b10000);
    tick();
    chk_out("bp1", 1'b1, 3'd4, 128'h400);
    put(4, 1'b1, 1'b1, 1'b1, 128'h402);
    settle();
    chk("bp2.in_ready", in_ready, 5'b00000);
    tick();
    chk_out("bp2", 1'b1, 3'd4, 128'h400);
    out_ready = 1'b1;
    settle();
    chk("bp_rel.in_ready", in_ready, 5'b00000);
    tick();
    chk_out("bp_rel", 1'b1, 3'd4, 128'h401);
    settle();
    chk("bp_fill.in_ready", in_ready, 5'b10000);
    tick();
    chk_out("bp_fill", 1'b1, 3'd4, 128'h402);
    in_valid = '0;
    tick();
    chk("bp.drained", out_valid, 1'b0);

    // reset in the middle of a 2-beat packet from input 2
    put(2, 1'b1, 1'b1, 1'b0, 128'h501);
    settle();
    chk("mid.in_ready", in_ready, 5'b00100);
    tick();
    chk_out("mid", 1'b1, 3'd2, 128'h501);
    reset = 1'b1;
    put(2, 1'b1, 1'b0, 1'b1, 128'h502);
    put(0, 1'b1, 1'b1, 1'b1, 128'h200);
    settle();
    chk("mid_rst.in_ready", in_ready, 5'b00000);
    tick();
    chk("mid_rst.out_valid", out_valid, 1'b0);
    reset = 1'b0;
    put(2, 1'b1, 1'b1, 1'b1, 128'h503);
    settle();
    chk("post_rst.in_ready", in_ready, 5'b00001);
    tick();
    chk_out("post_rst", 1'b1, 3'd0, 128'h200);

    // five stalled cycles with a beat held in main
    in_valid  = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      tick();
    chk_out("stall", 1'b1, 3'd0, 128'h200);
`ifdef SFU_COMMIT_PERF_EN
    chk("perf.stall", perf_stall_cycles, 64'd5);
    chk("perf.lock_block", perf_lock_block_cycles, 64'd0);
`endif
    out_ready = 1'b1;
    tick();
    chk("stall.drained", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
